tick_timer_arbiter: RTL and testbench
=====================================

# tick_timer_arbiter

Round-robin arbiter and sequencer that shares one prescaled tick counter among `N_REQ` requesters. Each requester asks for a delay in prescaler ticks, one tick being `DIV` system clocks. The block grants the counter to one requester at a time, runs the countdown, and pulses that requester's `done` when the delay expires. It sits between the control FSMs that need timed waits and the system clock, and replaces one free-running divider per FSM.

## Interface
- `N_REQ`, default 4: number of requesters, ≥2.
- `DIV`, default 50: system clocks per tick, ≥1. The default gives a 1 MHz tick from 50 MHz.
- `CW`, default 16: delay field width.

- `clk`, input, 1: system clock. All logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `req`, input, `N_REQ`: level request per requester. The requester holds it until it sees `ack`.
- `delay`, input, `N_REQ*CW`: delay for requester i, in ticks, at bits `[i*CW +: CW]`. Sampled only in the grant cycle.
- `abort`, input, 1: cancels the active job.
- `ack`, output, `N_REQ`: one-hot grant pulse, one cycle long.
- `done`, output, `N_REQ`: one-hot completion pulse, one cycle long.
- `busy`, output, 1: high while in COUNT or DONE.
- `owner`, output, `$clog2(N_REQ)`: index of the granted requester. Valid while `busy`.
- `tick_out`, output, 1: one-cycle pulse on each prescaler wrap in COUNT.

## Operation
- Reset state:
  - state = IDLE.
  - `ack`, `done`, `busy`, `owner`, `tick_out`, prescaler and remaining count all = 0.
  - `last` = `N_REQ-1`.
- IDLE:
  - If `req` is nonzero, pick the winner w as the first set bit scanning upward from `last+1`, wrapping modulo `N_REQ`.
  - Latch `remaining` = `delay[w]` and set `owner` = w.
  - Clear the prescaler and go to COUNT.
  - `ack[w]` is registered, so it is high during the first COUNT cycle.
- COUNT:
  - The prescaler counts 0 to `DIV-1` and wraps to 0. `tick_out` = 1 in cycles where the prescaler = `DIV-1`.
  - Each tick decrements `remaining`.
  - When the tick brings `remaining` from 1 to 0, go to DONE.
  - If `remaining` = 0 on entry (delay 0), go to DONE after one COUNT cycle with no tick.
- DONE: `done[owner]` = 1 for this one cycle. Set `last` = `owner` and go to IDLE.
- `abort`:
  - Acts only in COUNT. Go straight to IDLE.
  - No `done` is issued, `last` is still updated to `owner`, and `busy` drops next cycle.
  - When `abort` coincides with the final tick, `abort` wins and no `done` is issued.
  - `abort` is ignored in IDLE and DONE.
- A requester still holding `req` after its `ack` is treated as a new request.
- Changes to `req` or `delay` during COUNT have no effect on the running job.
- `reset` asserted in any state drops the job immediately; no `done` or `ack` follows.
- Arithmetic: the prescaler is `$clog2(DIV)` bits wide, with a minimum of 1 bit; `DIV` = 1 gives a tick every COUNT cycle. `remaining` is `CW` bits and never underflows.

## Timing
- `req` first sampled high in IDLE cycle t gives `ack` at t+1.
- `done` arrives at t+1+max(D·DIV, 1). COUNT lasts exactly D·DIV cycles, or 1 cycle for D = 0.
- IDLE is reached at t+2+max(D·DIV, 1). The earliest next `ack` is one cycle after that, so the minimum gap from `done` to the next `ack` is 2 cycles.
- `tick_out` pulses for a delay of D fall in COUNT cycles k·DIV−1, for k = 1..D, counting COUNT cycles from 0.
- `busy` rises with `ack` and falls the cycle after `done`.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
All scenarios use `N_REQ`=4, `DIV`=5, `CW`=8.
1. Release `reset`, then drive `req[2]`=1 with `delay2`=3 → `ack`=0100 one cycle later, three `tick_out` pulses 5 cycles apart, `done`=0100 15 cycles after `ack`, and `busy` high for 16 cycles.
2. Hold `req`=1111 with all delays = 1 → grant order 0,1,2,3,0, with `done` 5 cycles after each `ack` and `ack` pulses spaced 7 cycles apart.
3. Request with delay 0 → `done` exactly 1 cycle after `ack`, and `tick_out` never pulses.
4. Request with delay 3 and assert `abort` in COUNT cycle 7 → exactly one `tick_out`, no `done`, `busy` low next cycle, and next grant starts after that requester.
5. Assert `abort` in the same cycle as the final tick → no `done`. Separately, assert `reset` mid-COUNT → all outputs 0 next cycle; then `req`=1010 grants index 1 first.
6. Drive `req[0]` during requester 3's COUNT and change `delay3` mid-COUNT → requester 3 completes with its original delay, then requester 0 is granted 2 cycles after `done[3]`.

Source files
------------

// File: rtl/tick_timer_arbiter.sv
// tick_timer_arbiter: hands one prescaled down-counter to N_REQ requesters in
// round-robin order. It counts the granted requester's delay in ticks of DIV
// clocks and then pulses that requester's done.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | no job; pick the next requester after last, latch its delay
//   S_COUNT | prescaler running; each wrap is one tick off remaining
//   S_DONE  | done[owner] is high this cycle; last <= owner, back to IDLE
module tick_timer_arbiter #(
  parameter int N_REQ = 4,
  parameter int DIV   = 50,
  parameter int CW    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*CW-1:0]        delay,
  input  logic                       abort,
  output logic [N_REQ-1:0]           ack,
  output logic [N_REQ-1:0]           done,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   owner,
  output logic                       tick_out
);

  localparam int OW = $clog2(N_REQ);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX  = PW'(DIV - 1);
  localparam logic [OW-1:0] LAST_RST = OW'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [OW-1:0]     last_q, last_d;
  logic [CW-1:0]     rem_q, rem_d;
  logic [PW-1:0]     pre_q, pre_d;
  logic              tick_q, tick_d;

  logic [OW-1:0]     win;
  logic              found;
  logic [CW-1:0]     win_delay;
  logic              tick_now;

  // Round-robin pick: first set req bit scanning upward from last+1, wrapping.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!found && req[(int'(last_q) + i) % N_REQ]) begin
        win   = OW'((int'(last_q) + i) % N_REQ);
        found = 1'b1;
      end
    end
  end

  assign win_delay = delay[int'(win)*CW +: CW];
  // A tick only counts while there is something left to count; a zero delay
  // leaves COUNT after one cycle without ever ticking, even with DIV = 1.
  assign tick_now  = (pre_q == PRE_MAX) && (rem_q != '0);

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    ack_d   = '0;
    done_d  = '0;
    owner_d = owner_q;
    last_d  = last_q;
    rem_d   = rem_q;
    pre_d   = pre_q;
    tick_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d      = S_COUNT;
          ack_d[win]   = 1'b1;
          owner_d      = win;
          rem_d        = win_delay;
          pre_d        = '0;
          tick_d       = (PRE_MAX == '0) && (win_delay != '0);
        end
      end
      S_COUNT: begin
        if (abort) begin
          state_d = S_IDLE;
          last_d  = owner_q;
          pre_d   = '0;
        end else if (rem_q == '0) begin
          state_d         = S_DONE;
          done_d[owner_q] = 1'b1;
        end else begin
          pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
          if (tick_now) begin
            rem_d = rem_q - 1'b1;
            if (rem_q == CW'(1)) begin
              state_d         = S_DONE;
              done_d[owner_q] = 1'b1;
            end
          end
          if (state_d == S_COUNT) tick_d = (pre_d == PRE_MAX);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        last_d  = owner_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ack_q   <= '0;
      done_q  <= '0;
      owner_q <= '0;
      last_q  <= LAST_RST;
      rem_q   <= '0;
      pre_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      rem_q   <= rem_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
    end
  end

  assign ack      = ack_q;
  assign done     = done_q;
  assign owner    = owner_q;
  assign tick_out = tick_q;
  assign busy     = (state_q == S_COUNT) || (state_q == S_DONE);

endmodule

// File: tb/tb_tick_timer_arbiter.sv
// Bench for tick_timer_arbiter: a job-level timing model predicts every output
// each cycle, and directed scenarios pin the model with literal timings.
module tb_tick_timer_arbiter;
  localparam int N_REQ = 4;
  localparam int DIV   = 5;
  localparam int CW    = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [N_REQ-1:0]   req = '0;
  logic [N_REQ*CW-1:0] delay = '0;
  logic               abort = 1'b0;
  logic [N_REQ-1:0]   ack, done;
  logic               busy, tick_out;
  logic [1:0]         owner;

  tick_timer_arbiter #(.N_REQ(N_REQ), .DIV(DIV), .CW(CW)) dut (
    .clk(clk), .reset(reset), .req(req), .delay(delay), .abort(abort),
    .ack(ack), .done(done), .busy(busy), .owner(owner), .tick_out(tick_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int oh2i(input logic [N_REQ-1:0] v);
    for (int i = 0; i < N_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Job-level model: a grant fixes the whole timeline (ack, ticks, done) by arithmetic.
  int  cyc = 0;
  bit  mv = 0;
  bit  m_active = 0;
  int  m_last = N_REQ - 1;
  int  m_owner = 0, m_D = 0, m_start = 0, m_done_at = 0;
  logic [N_REQ-1:0] e_ack = '0, e_done = '0;
  logic e_busy = 1'b0, e_tick = 1'b0;

  always @(posedge clk) begin : model
    int n, c, w;
    bit found;
    n = cyc;
    if (reset) begin
      m_active = 0;
      m_last   = N_REQ - 1;
      mv       = 1;
    end else if (m_active) begin
      if ((abort && n < m_done_at) || n == m_done_at) begin
        m_active = 0;
        m_last   = m_owner;
      end
    end else if (req != '0) begin
      found = 0;
      w = 0;
      for (int k = 1; k <= N_REQ; k++) begin
        if (!found && req[(m_last + k) % N_REQ]) begin
          w = (m_last + k) % N_REQ;
          found = 1;
        end
      end
      m_owner   = w;
      m_D       = int'(delay[w*CW +: CW]);
      m_start   = n + 1;
      m_done_at = n + 1 + ((m_D == 0) ? 1 : m_D * DIV);
      m_active  = 1;
    end
    cyc = n + 1;
    c = cyc;
    e_ack  = '0;
    e_done = '0;
    e_busy = 1'b0;
    e_tick = 1'b0;
    if (m_active) begin
      if (c == m_start) e_ack[m_owner] = 1'b1;
      if (c == m_done_at) e_done[m_owner] = 1'b1;
      e_busy = (c >= m_start) && (c <= m_done_at);
      e_tick = (c >= m_start) && (c < m_done_at) && (m_D > 0) && ((c - m_start) % DIV == DIV - 1);
    end
  end

  // Event log used by the literal checks.
  int ack_cyc_q[$], ack_idx_q[$], done_cyc_q[$], done_idx_q[$], tick_cyc_q[$];
  int busy_cnt = 0;

  // Per-cycle compare against the model, plus event logging.
  always @(negedge clk) begin
    if (mv) begin
      chk("ack", int'(ack), int'(e_ack));
      chk("done", int'(done), int'(e_done));
      chk("busy", int'(busy), int'(e_busy));
      chk("tick_out", int'(tick_out), int'(e_tick));
      if (e_busy) chk("owner", int'(owner), m_owner);
      if (ack != '0) begin ack_cyc_q.push_back(cyc); ack_idx_q.push_back(oh2i(ack)); end
      if (done != '0) begin done_cyc_q.push_back(cyc); done_idx_q.push_back(oh2i(done)); end
      if (tick_out) tick_cyc_q.push_back(cyc);
      if (busy) busy_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    req = '0;
    abort = 1'b0;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  task automatic clr_log();
    ack_cyc_q.delete(); ack_idx_q.delete();
    done_cyc_q.delete(); done_idx_q.delete();
    tick_cyc_q.delete();
    busy_cnt = 0;
  endtask

  task automatic set_delay(input int i, input int v);
    delay[i*CW +: CW] = CW'(v);
  endtask

  task automatic wait_ack(input int i, input int budget);
    bit ok;
    ok = 0;
    for (int k = 0; k < budget && !ok; k++) begin
      step(1);
      if (ack[i]) ok = 1;
    end
    chk($sformatf("wait_ack%0d", i), int'(ok), 1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int exp_ord[5] = '{0, 1, 2, 3, 0};
    step(3);

    // 1: single request, delay 3
    do_reset(); clr_log();
    set_delay(2, 3);
    req = 4'b0100;
    wait_ack(2, 10);
    req = '0;
    step(20);
    chk("s1_ack_cnt", ack_cyc_q.size(), 1);
    chk("s1_done_cnt", done_cyc_q.size(), 1);
    if (ack_cyc_q.size() >= 1 && done_cyc_q.size() >= 1) begin
      chk("s1_ack_idx", ack_idx_q[0], 2);
      chk("s1_done_idx", done_idx_q[0], 2);
      chk("s1_done_lat", done_cyc_q[0] - ack_cyc_q[0], 15);
    end
    chk("s1_ticks", tick_cyc_q.size(), 3);
    if (tick_cyc_q.size() == 3) begin
      chk("s1_tick_gap0", tick_cyc_q[1] - tick_cyc_q[0], 5);
      chk("s1_tick_gap1", tick_cyc_q[2] - tick_cyc_q[1], 5);
    end
    chk("s1_busy_len", busy_cnt, 16);

    // 2: all requesting, delay 1 each
    do_reset(); clr_log();
    for (int i = 0; i < N_REQ; i++) set_delay(i, 1);
    req = 4'b1111;
    step(33);
    req = '0;
    step(12);
    chk("s2_ack_cnt", ack_idx_q.size(), 5);
    if (ack_idx_q.size() == 5 && done_cyc_q.size() == 5) begin
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("s2_order%0d", k), ack_idx_q[k], exp_ord[k]);
        chk($sformatf("s2_done_lat%0d", k), done_cyc_q[k] - ack_cyc_q[k], 5);
        if (k < 4) chk($sformatf("s2_ack_gap%0d", k), ack_cyc_q[k+1] - ack_cyc_q[k], 7);
      end
    end

    // 3: delay 0
    do_reset(); clr_log();
    set_delay(1, 0);
    req = 4'b0010;
    wait_ack(1, 10);
    req = '0;
    step(5);
    chk("s3_done_cnt", done_cyc_q.size(), 1);
    if (done_cyc_q.size() == 1 && ack_cyc_q.size() == 1)
      chk("s3_done_lat", done_cyc_q[0] - ack_cyc_q[0], 1);
    chk("s3_ticks", tick_cyc_q.size(), 0);

    // 4: abort in COUNT cycle 7
    do_reset(); clr_log();
    set_delay(1, 3);
    set_delay(3, 1);
    req = 4'b0010;
    wait_ack(1, 10);
    req = '0;
    step(7);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("s4_busy_low", int'(busy), 0);
    chk("s4_ticks", tick_cyc_q.size(), 1);
    chk("s4_no_done", done_cyc_q.size(), 0);
    req = 4'b1011;
    step(1);
    chk("s4_next_grant", int'(ack), 4'b1000);
    req = '0;
    step(10);

    // 5a: abort together with the final tick
    do_reset(); clr_log();
    set_delay(0, 1);
    req = 4'b0001;
    wait_ack(0, 10);
    req = '0;
    step(4);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("s5_busy_low", int'(busy), 0);
    step(5);
    chk("s5_no_done", done_cyc_q.size(), 0);

    // 5b: reset mid-COUNT, then req 1010 grants index 1 first
    do_reset(); clr_log();
    set_delay(2, 3);
    set_delay(1, 2);
    set_delay(3, 1);
    req = 4'b0100;
    wait_ack(2, 10);
    req = '0;
    step(5);
    reset = 1'b1;
    step(1);
    chk("s5_rst_ack", int'(ack), 0);
    chk("s5_rst_done", int'(done), 0);
    chk("s5_rst_busy", int'(busy), 0);
    chk("s5_rst_owner", int'(owner), 0);
    chk("s5_rst_tick", int'(tick_out), 0);
    reset = 1'b0;
    req = 4'b1010;
    step(1);
    chk("s5_first_grant", int'(ack), 4'b0010);
    req = 4'b1000;
    wait_ack(3, 30);
    req = '0;
    step(10);

    // 6: req/delay changes during COUNT do not disturb the running job
    do_reset(); clr_log();
    set_delay(3, 4);
    set_delay(0, 1);
    req = 4'b1000;
    wait_ack(3, 10);
    req = '0;
    step(3);
    req = 4'b0001;
    set_delay(3, 9);
    wait_ack(0, 40);
    req = '0;
    step(10);
    chk("s6_done_cnt", done_cyc_q.size(), 2);
    if (done_cyc_q.size() >= 1 && ack_cyc_q.size() >= 2) begin
      chk("s6_done_idx", done_idx_q[0], 3);
      chk("s6_done_lat", done_cyc_q[0] - ack_cyc_q[0], 20);
      chk("s6_next_idx", ack_idx_q[1], 0);
      chk("s6_gap", ack_cyc_q[1] - done_cyc_q[0], 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
